// File: rtl/mccpu_mem_handshake_if.sv
// Unified memory port between the multicycle core and its memory.
//   master (core)  : drives mem_req, mem_we, mem_addr, mem_wdata; receives mem_rdata, mem_ready
//   slave  (memory): the reverse directions
// An access completes in any cycle where mem_req and mem_ready are both high.
interface mccpu_mem_handshake_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mccpu_mem_handshake.sv
// Multicycle MIPS-subset core (FETCH/DECODE/EXEC/MEM/WB/HALT) on one
// handshaked memory port with a bus-timeout halt.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   bus          mccpu_mem_handshake_if.master memory port
//   instruction  instruction register
//   pcOut        current PC
//   halted       core stopped (illegal opcode or bus timeout), cleared by reset
// Optional build macro: MCCPU_JAL_EN adds jal and jr; without it both halt.
module mccpu_mem_handshake #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BUS_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  mccpu_mem_handshake_if.master        bus,
  output logic [31:0]                  instruction,
  output logic [31:0]                  pcOut,
  output logic                         halted
);

  localparam int unsigned WCNT_W = 8;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
`ifdef MCCPU_JAL_EN
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;
`endif

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t              state;
  logic [31:0]         pc;
  logic [31:0]         ir;
  logic [31:0]         a;
  logic [31:0]         b;
  logic [31:0]         alu_out;
  logic [31:0]         mdr;
  logic [WCNT_W-1:0]   wait_cnt;
  logic [31:0]         regs [32];

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] imm_sext;
  logic [31:0] eff_addr;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic        timeout;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};
  assign eff_addr = a + imm_sext;
  assign wb_dst   = (opcode == OP_RTYPE) ? rd : rt;
  assign wb_data  = (opcode == OP_LW) ? mdr : alu_out;
  // Fires on the last tolerated unanswered cycle, so HALT follows the BUS_TIMEOUT-th one.
  assign timeout  = (wait_cnt == WCNT_W'(BUS_TIMEOUT - 1));

  assign instruction = ir;
  assign pcOut       = pc;

  function automatic logic [31:0] word_addr(input logic [31:0] x);
    return x & 32'hFFFF_FFFC;
  endfunction

  // Opcode legality, ALU result, and the next PC for control-flow instructions.
  logic        legal;
  logic        to_mem;
  logic        to_wb;
  logic [31:0] alu_res;
  logic [31:0] exec_pc;

  always_comb begin
    legal   = 1'b0;
    to_mem  = 1'b0;
    to_wb   = 1'b0;
    alu_res = '0;
    exec_pc = pc;
    case (opcode)
      OP_RTYPE: begin
        legal = 1'b1;
        to_wb = 1'b1;
        case (funct)
          FN_ADD: alu_res = a + b;
          FN_SUB: alu_res = a - b;
          FN_AND: alu_res = a & b;
          FN_OR:  alu_res = a | b;
          FN_SLT: alu_res = {31'b0, ($signed(a) < $signed(b))};
`ifdef MCCPU_JAL_EN
          FN_JR: begin
            to_wb   = 1'b0;
            exec_pc = a;
          end
`endif
          default: begin
            legal = 1'b0;
            to_wb = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        legal   = 1'b1;
        to_wb   = 1'b1;
        alu_res = a + imm_sext;
      end
      OP_LUI: begin
        legal   = 1'b1;
        to_wb   = 1'b1;
        alu_res = {ir[15:0], 16'h0000};
      end
      OP_LW, OP_SW: begin
        legal  = 1'b1;
        to_mem = 1'b1;
      end
      OP_BEQ: begin
        legal = 1'b1;
        if (a == b) exec_pc = alu_out;
      end
      OP_BNE: begin
        legal = 1'b1;
        if (a != b) exec_pc = alu_out;
      end
      OP_J: begin
        legal   = 1'b1;
        exec_pc = {pc[31:28], ir[25:0], 2'b00};
      end
`ifdef MCCPU_JAL_EN
      OP_JAL: begin
        legal   = 1'b1;
        exec_pc = {pc[31:28], ir[25:0], 2'b00};
      end
`endif
      default: ;
    endcase
  end

  // Control FSM with datapath registers; bus outputs are set on the edge entering FETCH/MEM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      ir            <= '0;
      a             <= '0;
      b             <= '0;
      alu_out       <= '0;
      mdr           <= '0;
      wait_cnt      <= '0;
      halted        <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= word_addr(RESET_PC);
      bus.mem_wdata <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          // Request is only low here in the first cycle out of reset.
          if (!bus.mem_req) begin
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= word_addr(pc);
          end else if (bus.mem_ready) begin
            ir          <= bus.mem_rdata;
            pc          <= pc + 32'd4;
            bus.mem_req <= 1'b0;
            wait_cnt    <= '0;
            state       <= DECODE;
          end else if (timeout) begin
            bus.mem_req <= 1'b0;
            halted      <= 1'b1;
            state       <= HALT;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        DECODE: begin
          a       <= regs[rs];
          b       <= regs[rt];
          alu_out <= pc + (imm_sext << 2);
          if (legal) begin
            state <= EXEC;
          end else begin
            halted <= 1'b1;
            state  <= HALT;
          end
        end
        EXEC: begin
          if (to_mem) begin
            alu_out       <= eff_addr;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= (opcode == OP_SW);
            bus.mem_addr  <= word_addr(eff_addr);
            bus.mem_wdata <= b;
            state         <= MEM;
          end else if (to_wb) begin
            alu_out <= alu_res;
            state   <= WB;
          end else begin
`ifdef MCCPU_JAL_EN
            if (opcode == OP_JAL) regs[31] <= pc;
`endif
            pc           <= exec_pc;
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= word_addr(exec_pc);
            state        <= FETCH;
          end
        end
        MEM: begin
          if (bus.mem_ready) begin
            wait_cnt <= '0;
            if (bus.mem_we) begin
              // Store done: roll straight into the next fetch, request stays high.
              bus.mem_we   <= 1'b0;
              bus.mem_addr <= word_addr(pc);
              state        <= FETCH;
            end else begin
              mdr         <= bus.mem_rdata;
              bus.mem_req <= 1'b0;
              state       <= WB;
            end
          end else if (timeout) begin
            bus.mem_req <= 1'b0;
            halted      <= 1'b1;
            state       <= HALT;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        WB: begin
          if (wb_dst != 5'd0) regs[wb_dst] <= wb_data;
          bus.mem_req  <= 1'b1;
          bus.mem_we   <= 1'b0;
          bus.mem_addr <= word_addr(pc);
          state        <= FETCH;
        end
        HALT: ;
        default: begin
          halted <= 1'b1;
          state  <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mccpu_mem_handshake.sv
// Directed bench for mccpu_mem_handshake: a word memory with programmable
// wait states and a stall override drives the slave side of the bus.
module tb_mccpu_mem_handshake;

  localparam int unsigned TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        halted;

  mccpu_mem_handshake_if bus ();

  mccpu_mem_handshake #(
    .RESET_PC    (32'h0000_0000),
    .BUS_TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .instruction (instruction),
    .pcOut       (pc_out),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Memory model
  logic [31:0] mem [64];
  logic [31:0] img [64];
  logic        load  = 1'b0;
  logic        stall = 1'b0;
  int          wait_n = 0;
  int          wcnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;
  int          stable_err = 0;
  logic        pw = 1'b0;
  logic        p_we = 1'b0;
  logic [31:0] p_addr = '0;
  logic [31:0] p_wdata = '0;

  assign bus.mem_ready = bus.mem_req && !stall && (wcnt >= wait_n);
  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 64; i++) mem[i] <= img[i];
    end else if (bus.mem_req && bus.mem_ready && bus.mem_we) begin
      mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= bus.mem_addr;
      last_wdata <= bus.mem_wdata;
    end
    if (bus.mem_req && !bus.mem_ready) wcnt <= wcnt + 1;
    else                               wcnt <= 0;
    // Request attributes must not move while a request is waiting.
    pw      <= bus.mem_req && !bus.mem_ready;
    p_addr  <= bus.mem_addr;
    p_we    <= bus.mem_we;
    p_wdata <= bus.mem_wdata;
    if (pw && bus.mem_req &&
        (bus.mem_addr !== p_addr || bus.mem_we !== p_we || (p_we && bus.mem_wdata !== p_wdata)))
      stable_err <= stable_err + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic clear_img();
    for (int i = 0; i < 64; i++) img[i] = 32'h0;
  endtask

  // Returns the number of cycles until a fetch of target is first on the bus, -1 if none.
  task automatic wait_fetch(input logic [31:0] target, input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (bus.mem_req === 1'b1 && bus.mem_we === 1'b0 && bus.mem_addr === target) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Two reset edges, memory loaded from img; returns at the first fetch cycle.
  task automatic do_reset();
    rst  = 1'b0;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    check("rst_req",    {31'b0, bus.mem_req}, 32'd0);
    check("rst_halted", {31'b0, halted},      32'd0);
    check("rst_pc",     pc_out,               32'h0);
    check("rst_ir",     instruction,          32'h0);
    check("rst_r1",     dut.regs[1],          32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("first_req",  {31'b0, bus.mem_req}, 32'd1);
    check("first_addr", bus.mem_addr,         32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c;
    int wr_base;
    bit found;
    rst = 1'b0;

    // ALU program, zero-wait memory
    clear_img();
    img[0] = 32'h2001_0005;  // addi $1,$0,5
    img[1] = 32'h2002_FFFD;  // addi $2,$0,-3
    img[2] = 32'h0022_1820;  // add  $3,$1,$2
    img[3] = 32'h0041_202A;  // slt  $4,$2,$1
    img[4] = 32'h3C06_ABCD;  // lui  $6,0xABCD
    img[5] = 32'h0041_3822;  // sub  $7,$2,$1
    img[6] = 32'h2000_0007;  // addi $0,$0,7
    img[7] = 32'hFC00_0000;  // illegal
    wait_n = 0;
    do_reset();
    wait_fetch(32'h10, 100, c);
    check("alu_cycles", 32'(c), 32'd16);
    check("alu_r2", dut.regs[2], 32'hFFFF_FFFD);
    check("alu_r3", dut.regs[3], 32'd2);
    check("alu_r4", dut.regs[4], 32'd1);
    wait_fetch(32'h1C, 100, c);
    check("lui_r6", dut.regs[6], 32'hABCD_0000);
    check("sub_r7", dut.regs[7], 32'hFFFF_FFF8);
    check("r0_zero", dut.regs[0], 32'h0);

    // Store then load, two wait states per access
    clear_img();
    img[0]  = 32'h2001_0005;  // addi $1,$0,5
    img[1]  = 32'h0800_0008;  // j    0x20
    img[8]  = 32'hAC01_0008;  // sw   $1,8($0)
    img[9]  = 32'h8C05_0008;  // lw   $5,8($0)
    img[10] = 32'hFC00_0000;  // illegal
    wait_n = 2;
    do_reset();
    wait_fetch(32'h20, 200, c);
    wr_base = wr_cnt;
    wait_fetch(32'h24, 50, c);
    check("sw_cycles", 32'(c), 32'd8);
    check("sw_count", 32'(wr_cnt - wr_base), 32'd1);
    check("sw_addr", last_waddr, 32'h8);
    check("sw_data", last_wdata, 32'd5);
    wait_fetch(32'h28, 50, c);
    check("lw_cycles", 32'(c), 32'd9);
    check("lw_r5", dut.regs[5], 32'd5);

    // beq back onto itself
    clear_img();
    img[0] = 32'h0800_0004;  // j   0x10
    img[4] = 32'h1021_FFFF;  // beq $1,$1,-1
    wait_n = 0;
    do_reset();
    wait_fetch(32'h10, 20, c);
    check("j_cycles", 32'(c), 32'd3);
    wait_fetch(32'h10, 20, c);
    check("beq_loop1", 32'(c), 32'd3);
    wait_fetch(32'h10, 20, c);
    check("beq_loop2", 32'(c), 32'd3);

    // bne on equal operands falls through
    clear_img();
    img[0] = 32'h0800_0004;  // j   0x10
    img[4] = 32'h1421_FFFF;  // bne $1,$1,-1
    img[5] = 32'hFC00_0000;
    do_reset();
    wait_fetch(32'h10, 20, c);
    wait_fetch(32'h14, 20, c);
    check("bne_fall", 32'(c), 32'd3);

    // Bus timeout during the second fetch
    clear_img();
    img[0] = 32'h2001_0005;  // addi $1,$0,5
    do_reset();
    wait_fetch(32'h4, 20, c);
    check("to_fetch_cycles", 32'(c), 32'd4);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    check("to_req_before", {31'b0, bus.mem_req}, 32'd1);
    check("to_halt_before", {31'b0, halted}, 32'd0);
    @(negedge clk);
    check("to_halted", {31'b0, halted}, 32'd1);
    check("to_req_low", {31'b0, bus.mem_req}, 32'd0);
    check("to_pc", pc_out, 32'h4);
    stall = 1'b0;
    repeat (5) @(negedge clk);
    check("to_pc_frozen", pc_out, 32'h4);
    check("to_still_halted", {31'b0, halted}, 32'd1);
    check("to_req_stays_low", {31'b0, bus.mem_req}, 32'd0);
    check("to_r1", dut.regs[1], 32'd5);

    // Illegal opcode, then a one-cycle reset pulse
    clear_img();
    img[0] = 32'hFC00_0000;
    do_reset();
    @(negedge clk);
    check("ill_decode_run", {31'b0, halted}, 32'd0);
    @(negedge clk);
    check("ill_halted", {31'b0, halted}, 32'd1);
    check("ill_ir", instruction, 32'hFC00_0000);
    check("ill_req", {31'b0, bus.mem_req}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("pulse_halted", {31'b0, halted}, 32'd0);
    check("pulse_req", {31'b0, bus.mem_req}, 32'd0);
    check("pulse_pc", pc_out, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("pulse_refetch_req", {31'b0, bus.mem_req}, 32'd1);
    check("pulse_refetch_addr", bus.mem_addr, 32'h0);

    // Reset during a waiting lw data access
    clear_img();
    img[0] = 32'h8C05_0020;  // lw $5,0x20($0)
    img[8] = 32'h0000_1234;
    wait_n = 2;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.mem_req === 1'b1 && bus.mem_addr === 32'h20 && bus.mem_ready === 1'b0) found = 1'b1;
    end
    check("abort_mem_seen", {31'b0, found}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_req", {31'b0, bus.mem_req}, 32'd0);
    check("abort_r5", dut.regs[5], 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_refetch", bus.mem_addr, 32'h0);

    // jal: legal only when the option is built in
    clear_img();
    img[0]  = 32'h0C00_0010;  // jal 0x40
    img[16] = 32'hFC00_0000;
    wait_n = 0;
    do_reset();
`ifdef MCCPU_JAL_EN
    wait_fetch(32'h40, 20, c);
    check("jal_cycles", 32'(c), 32'd3);
    check("jal_r31", dut.regs[31], 32'h4);
    check("jal_pc", pc_out, 32'h40);
`else
    repeat (2) @(negedge clk);
    check("jal_illegal_halt", {31'b0, halted}, 32'd1);
    check("jal_pc_frozen", pc_out, 32'h4);
`endif

    check("wait_stable", 32'(stable_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
